// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared op codes, mode bit position and sequencer states for the mac datapath
package mac_pkg;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_SAT  = 2'b11;

  localparam int MODE_BIT = 2;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    ACC,
    SAT,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [2:0] mk_instr(input logic mode, input logic [1:0] op);
    logic [2:0] instr;
    instr           = 3'b000;
    instr[MODE_BIT] = mode;
    instr[1:0]      = op;
    return instr;
  endfunction

endpackage

// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - operand-pair valid/ready stream into the mac sequencer
interface mac_seq_if;

  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;

  modport master (output op_valid, output op_a, output op_b, input op_ready);
  modport slave  (input op_valid, input op_a, input op_b, output op_ready);

endinterface

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequences one dot-product job through an external mac and captures its result
module mac_seq
  import mac_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  input  logic             sat_en,
  input  logic             abort,
  mac_seq_if.slave         ops,
  output logic [2:0]       mac_instruction,
  output logic [15:0]      mac_multiplier,
  output logic [15:0]      mac_multiplicand,
  output logic             mac_stall,
  input  logic [31:0]      mac_result,
  input  logic [7:0]       mac_protect,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic [7:0]       protect
);

  localparam int DW = $clog2(MAC_LAT + 1);

  state_t           state;
  logic             j_mode;
  logic             j_sat;
  logic [LEN_W-1:0] remain;
  logic [DW-1:0]    drain_cnt;
  logic             hs;
  logic             last;

  assign ops.op_ready = (state == FIRST) || (state == ACC);
  assign hs           = ops.op_valid && ops.op_ready;
  assign last         = (remain == LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      j_mode           <= 1'b0;
      j_sat            <= 1'b0;
      remain           <= '0;
      drain_cnt        <= '0;
      mac_instruction  <= 3'b000;
      mac_multiplier   <= '0;
      mac_multiplicand <= '0;
      mac_stall        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      result           <= '0;
      protect          <= '0;
    end else begin
      // Default is an idle clear with zero operands; states override below.
      done             <= 1'b0;
      mac_instruction  <= mk_instr(1'b0, OP_CLR);
      mac_multiplier   <= '0;
      mac_multiplicand <= '0;
      mac_stall        <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              j_mode    <= mode;
              j_sat     <= sat_en;
              remain    <= len;
              drain_cnt <= '0;
              busy      <= 1'b1;
              if (len == '0) begin
                state           <= DRAIN;
                mac_instruction <= mk_instr(mode, OP_CLR);
              end else begin
                state <= FIRST;
              end
            end
          end
          FIRST, ACC: begin
            if (hs) begin
              mac_instruction  <= mk_instr(j_mode, (state == FIRST) ? OP_LOAD : OP_ACC);
              mac_multiplier   <= ops.op_a;
              mac_multiplicand <= ops.op_b;
              remain           <= remain - LEN_W'(1);
              if (last) state <= j_sat ? SAT : DRAIN;
              else      state <= ACC;
            end else begin
              // A bubble before the load must keep the accumulator cleared.
              mac_instruction <= mk_instr(j_mode, (state == FIRST) ? OP_CLR : OP_ACC);
              mac_stall       <= 1'b1;
            end
          end
          SAT: begin
            mac_instruction <= mk_instr(j_mode, OP_SAT);
            state           <= DRAIN;
          end
          DRAIN: begin
            mac_instruction <= mk_instr(j_mode, OP_ACC);
            mac_stall       <= 1'b1;
            if (drain_cnt == DW'(MAC_LAT)) begin
              state   <= DONE;
              done    <= 1'b1;
              result  <= mac_result;
              protect <= mac_protect;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - randomized self-checking bench for mac_seq with an attached mac model
module tb_mac_seq;
  import mac_pkg::*;

  localparam int MAC_LAT = 2;
  localparam int LEN_W   = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  len = '0;
  logic        sat_en = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  mac_instruction;
  logic [15:0] mac_multiplier;
  logic [15:0] mac_multiplicand;
  logic        mac_stall;
  logic [31:0] mac_result;
  logic [7:0]  mac_protect;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [7:0]  protect;

  mac_seq_if ops();

  mac_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .len(len),
    .sat_en(sat_en), .abort(abort), .ops(ops.slave),
    .mac_instruction(mac_instruction), .mac_multiplier(mac_multiplier),
    .mac_multiplicand(mac_multiplicand), .mac_stall(mac_stall),
    .mac_result(mac_result), .mac_protect(mac_protect),
    .busy(busy), .done(done), .result(result), .protect(protect)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at cycle %0d", name, cyc);
  endtask

  // Mac environment: one input register stage, then the accumulator, so effects appear MAC_LAT cycles later.
  function automatic logic [19:0] lane_step(input logic [19:0] v, input logic [1:0] op, input int p);
    int s;
    case (op)
      2'b00:   return 20'd0;
      2'b01:   return 20'(p);
      2'b10:   return v + 20'(p);
      default: begin
        s = int'($signed(v));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 20'(s);
      end
    endcase
  endfunction

  function automatic logic [39:0] mac_step(input logic [39:0] acc, input logic [2:0] ins,
                                           input logic [15:0] a, input logic [15:0] b);
    longint p, s, maxv;
    logic [19:0] lo, hi;
    maxv = 2147483647;
    if (!ins[2]) begin
      p = longint'($signed(a)) * longint'($signed(b));
      case (ins[1:0])
        2'b00:   return 40'd0;
        2'b01:   return 40'(p);
        2'b10:   return acc + 40'(p);
        default: begin
          s = longint'($signed(acc));
          if (s > maxv) s = maxv;
          else if (s < -maxv - 1) s = -maxv - 1;
          return 40'(s);
        end
      endcase
    end
    lo = lane_step({acc[39:36], acc[31:16]}, ins[1:0], int'($signed(a[7:0])) * int'($signed(b[7:0])));
    hi = lane_step({acc[35:32], acc[15:0]}, ins[1:0], int'($signed(a[15:8])) * int'($signed(b[15:8])));
    return {lo[19:16], hi[19:16], lo[15:0], hi[15:0]};
  endfunction

  logic [2:0]  st_instr;
  logic [15:0] st_a, st_b;
  logic [39:0] acc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_instr <= '0; st_a <= '0; st_b <= '0; acc <= '0;
    end else begin
      st_instr <= mac_instruction;
      st_a     <= mac_multiplier;
      st_b     <= mac_multiplicand;
      acc      <= mac_step(acc, st_instr, st_a, st_b);
    end
  end
  assign mac_result  = acc[31:0];
  assign mac_protect = acc[39:32];

  // Job-level reference: dot products as plain sums and a timeline derived from handshake cycles.
  bit          job_active = 0, d_known = 0, prev_hs = 0, j_mode = 0, j_sat = 0;
  int          s_cyc = 0, k = 0, j_len = 0, h_last = 0, d_cyc = 0, prev_k = 0;
  int          hs_cnt = 0, done_seen = 0, done_pulses = 0, suml = 0, sumh = 0;
  longint      sum16 = 0;
  logic [15:0] prev_a = '0, prev_b = '0;
  logic [31:0] exp_res = '0;
  logic [7:0]  exp_prot = '0;

  task automatic ref_final();
    longint v, maxv;
    int l, h;
    maxv = 2147483647;
    if (!j_mode) begin
      v = sum16;
      if (j_sat && v > maxv) v = maxv;
      if (j_sat && v < -maxv - 1) v = -maxv - 1;
      exp_res  = 32'(v);
      exp_prot = 8'(v >>> 32);
    end else begin
      l = suml; h = sumh;
      if (j_sat) begin
        if (l > 32767) l = 32767; else if (l < -32768) l = -32768;
        if (h > 32767) h = 32767; else if (h < -32768) h = -32768;
      end
      exp_res  = {16'(l), 16'(h)};
      exp_prot = {4'(l >>> 16), 4'(h >>> 16)};
    end
  endtask

  initial begin : compare
    logic [2:0]  e_instr;
    logic [15:0] e_a, e_b;
    logic        e_stall, e_ready, e_busy, e_done;
    bit          hs;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        job_active = 0; prev_hs = 0; d_known = 0; exp_res = '0; exp_prot = '0;
      end else begin
        e_instr = '0; e_a = '0; e_b = '0;
        e_stall = 0; e_ready = 0; e_busy = 0; e_done = 0;
        if (job_active) begin
          e_busy  = 1;
          e_ready = (k < j_len);
          e_done  = d_known && (cyc == d_cyc);
          if (cyc == s_cyc + 1) begin
            e_instr = (j_len == 0) ? {j_mode, OP_CLR} : 3'b000;
          end else if (prev_hs) begin
            e_instr = {j_mode, ((prev_k == 1) ? OP_LOAD : OP_ACC)};
            e_a = prev_a; e_b = prev_b;
          end else if (k < j_len) begin
            e_instr = {j_mode, ((k == 0) ? OP_CLR : OP_ACC)};
            e_stall = 1;
          end else if (j_sat && j_len != 0 && cyc == h_last + 2) begin
            e_instr = {j_mode, OP_SAT};
          end else begin
            e_instr = {j_mode, OP_ACC};
            e_stall = 1;
          end
          if (e_done) ref_final();
        end
        chk("instr", mac_instruction, e_instr);
        chk("mult_a", mac_multiplier, e_a);
        chk("mult_b", mac_multiplicand, e_b);
        chk("stall", mac_stall, e_stall);
        chk("op_ready", ops.op_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("result", result, exp_res);
        chk("protect", protect, exp_prot);
        if (done) begin done_seen = cyc; done_pulses++; end
        if (job_active) begin
          if (abort) begin
            job_active = 0; prev_hs = 0;
          end else begin
            hs = ops.op_valid && e_ready;
            prev_hs = hs;
            if (hs) begin
              k++; hs_cnt++; prev_k = k; prev_a = ops.op_a; prev_b = ops.op_b;
              sum16 += longint'($signed(ops.op_a)) * longint'($signed(ops.op_b));
              suml  += int'($signed(ops.op_a[7:0])) * int'($signed(ops.op_b[7:0]));
              sumh  += int'($signed(ops.op_a[15:8])) * int'($signed(ops.op_b[15:8]));
              if (k == j_len) begin
                h_last = cyc; d_cyc = cyc + 1 + int'(j_sat) + MAC_LAT + 1; d_known = 1;
              end
            end
            if (d_known && cyc == d_cyc) begin job_active = 0; prev_hs = 0; end
          end
        end else if (start) begin
          job_active = 1; s_cyc = cyc; j_mode = mode; j_len = int'(len); j_sat = sat_en;
          k = 0; sum16 = 0; suml = 0; sumh = 0; prev_hs = 0;
          d_known = (len == 0);
          d_cyc   = cyc + 1 + MAC_LAT + 1;
        end
      end
    end
  end

  logic [15:0] pa [256];
  logic [15:0] pb [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_busy();
    return job_active && (!d_known || cyc <= d_cyc);
  endfunction

  task automatic start_job(input logic m, input int n, input logic se);
    int w = 0;
    while (model_busy() && w < 2000) begin tick(); w++; end
    if (w >= 2000) timeout_fail("idle_wait");
    start = 1; mode = m; len = n[7:0]; sat_en = se;
    tick();
    start = 0; mode = 1'($urandom); len = 8'($urandom); sat_en = 1'($urandom);
  endtask

  task automatic feed_pair(input int i);
    int base, w;
    ops.op_valid = 1; ops.op_a = pa[i]; ops.op_b = pb[i];
    base = hs_cnt; w = 0;
    do begin tick(); w++; end while (hs_cnt == base && w < 50);
    if (hs_cnt == base) timeout_fail("handshake_wait");
    ops.op_valid = 0;
  endtask

  task automatic run_job(input logic m, input int n, input logic se, input int gap, input bit noise);
    int g, w;
    start_job(m, n, se);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
      for (int j = 0; j < g; j++) begin
        ops.op_valid = 0; ops.op_a = 16'($urandom); ops.op_b = 16'($urandom);
        start = noise && ($urandom_range(0, 3) == 0);
        tick();
      end
      start = 0;
      feed_pair(i);
    end
    w = 0;
    while (model_busy() && w < 50) begin
      start = noise && (cyc == d_cyc);
      ops.op_valid = noise && ($urandom_range(0, 1) == 1);
      tick(); w++;
    end
    if (w >= 50) timeout_fail("job_end_wait");
    start = 0; ops.op_valid = 0;
  endtask

  task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b);
    pa[i] = a; pb[i] = b;
  endtask

  initial begin : main
    int d0, lat0;
    ops.op_valid = 0; ops.op_a = '0; ops.op_b = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_protect", protect, 0);
    chk("rst_instr", mac_instruction, 0);
    chk("rst_ready", ops.op_ready, 0);
    chk("rst_stall", mac_stall, 0);
    reset_n = 1;
    repeat (2) tick();

    set_pair(0, 16'd3, 16'd4); set_pair(1, -16'sd2, 16'd5); set_pair(2, 16'd100, 16'd100);
    run_job(0, 3, 0, 0, 0);
    chk("tp1_result", result, 32'h0000_2712);
    chk("tp1_protect", protect, 8'h00);
    chk("tp1_latency", done_seen - s_cyc, 3 + MAC_LAT + 2);

    for (int i = 0; i < 5; i++) set_pair(i, 16'($urandom), 16'($urandom));
    d0 = done_pulses;
    start_job(0, 5, 0);
    feed_pair(0); feed_pair(1);
    ops.op_valid = 1; ops.op_a = pa[2]; ops.op_b = pb[2]; abort = 1;
    tick();
    abort = 0; ops.op_valid = 0;
    repeat (8) tick();
    chk("abort_no_done", done_pulses - d0, 0);
    chk("abort_result", result, 32'h0000_2712);
    chk("abort_busy", busy, 0);

    for (int i = 0; i < 3; i++) set_pair(i, 16'h7fff, 16'h7fff);
    run_job(0, 3, 1, 0, 0);
    chk("sat_result", result, 32'h7fff_ffff);
    chk("sat_protect", protect, 8'h00);
    chk("sat_latency", done_seen - s_cyc, 3 + MAC_LAT + 3);
    run_job(0, 3, 0, 0, 0);
    chk("nosat_result", result, 32'hbffd_0003);
    chk("nosat_protect", protect, 8'h00);

    set_pair(0, 16'h0302, 16'h0405);
    run_job(1, 1, 0, 0, 0);
    chk("dual_result", result, 32'h000a_000c);

    set_pair(0, 16'd7, -16'sd9); set_pair(1, 16'd1000, -16'sd3);
    run_job(0, 2, 0, 0, 0);
    lat0 = done_seen - s_cyc;
    chk("gapless_result", result, 32'hffff_f409);
    chk("gapless_protect", protect, 8'hff);
    run_job(0, 2, 0, 3, 0);
    chk("gapped_result", result, 32'hffff_f409);
    chk("gapped_latency", done_seen - s_cyc, lat0 + 3);

    d0 = done_pulses;
    run_job(1, 0, 1, 0, 1);
    chk("len0_result", result, 32'h0);
    chk("len0_protect", protect, 8'h0);
    chk("len0_latency", done_seen - s_cyc, MAC_LAT + 2);
    chk("len0_one_done", done_pulses - d0, 1);

    for (int i = 0; i < 255; i++) set_pair(i, 16'($urandom), 16'($urandom));
    run_job(0, 255, 0, 0, 0);
    chk("len255_latency", done_seen - s_cyc, 255 + MAC_LAT + 2);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 8; i++) begin
        set_pair(i, 16'($urandom), 16'($urandom));
        if ($urandom_range(0, 3) == 0) set_pair(i, 16'h7fff, ($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000);
      end
      run_job(1'($urandom), (r % 10 == 0) ? 0 : int'($urandom_range(1, 8)), 1'($urandom), -1, 1);
    end

    for (int i = 0; i < 6; i++) set_pair(i, 16'($urandom), 16'($urandom));
    start_job(1, 6, 1);
    feed_pair(0); feed_pair(1);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_protect", protect, 0);
    chk("mid_rst_instr", mac_instruction, 0);
    chk("mid_rst_mult", {mac_multiplier, mac_multiplicand}, 0);
    chk("mid_rst_ready", ops.op_ready, 0);
    repeat (2) tick();
    reset_n = 1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
